// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: valid/ready byte stream carrying received UART bytes.
//   m_valid  producer -> consumer  m_data holds the FIFO head
//   m_data   producer -> consumer  received byte
//   m_ready  consumer -> producer  head accepted when m_valid && m_ready
interface uart_rx_fifo_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver (LSB first, idle high) feeding a byte FIFO
// that is drained over a valid/ready stream. Sticky framing/overrun status.
//   clk        single clock for all logic
//   resetn     asynchronous active-low reset
//   cfg_div    clocks per bit (values < 2 act as 2), latched at start-bit detect
//   ser_rx     serial input, asynchronous to clk
//   stream     master side of uart_rx_fifo_if (m_valid, m_data, m_ready)
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte completed while FIFO full and not popping
//   err_clr    one-cycle pulse clearing both sticky flags (a set in the same cycle wins)
module uart_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [15:0]           cfg_div,
    input  logic                  ser_rx,
    uart_rx_fifo_if.master        stream,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Two-flop synchronizer; everything downstream looks at rx_s only.
    logic rx_m, rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= ser_rx;
            rx_s <= rx_m;
        end
    end

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [15:0] div_r;
    logic [15:0] half;
    logic [2:0]  bitn;
    logic [7:0]  sr;
    // Set after a framing error so a line held low (break) is not re-read
    // as a new start bit until it has gone high again.
    logic        wait_high;

    assign half = div_r >> 1;

    logic stop_hit, push_req, frame_set;
    assign stop_hit  = (state == ST_STOP) && (cnt == div_r - 16'd1);
    assign push_req  = stop_hit && rx_s;
    assign frame_set = stop_hit && !rx_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            div_r     <= 16'd2;
            bitn      <= '0;
            sr        <= '0;
            wait_high <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wait_high) begin
                        if (rx_s) wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                        div_r <= (cfg_div < 16'd2) ? 16'd2 : cfg_div;
                    end
                end
                ST_START: begin
                    if (cnt == half - 16'd1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= ST_DATA;
                            bitn  <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == div_r - 16'd1) begin
                        cnt  <= '0;
                        sr   <= {rx_s, sr[7:1]};
                        bitn <= bitn + 3'd1;
                        if (bitn == 3'd7) state <= ST_STOP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is caught.
                    if (stop_hit) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rx_s) wait_high <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // FIFO with one extra pointer bit to distinguish full from empty.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && stream.m_ready;
    assign push  = push_req && (!full || pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= sr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign stream.m_valid = !empty;
    assign stream.m_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;

            if (push_req && full && !pop) overrun <= 1'b1;
            else if (err_clr)             overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_div;
    logic        ser_rx;
    logic        frame_err, overrun, err_clr;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_div   (cfg_div),
        .ser_rx    (ser_rx),
        .stream    (bus.master),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned valid_cycles = 0;
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.m_valid === 1'b1) valid_cycles++;
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", {24'd0, bus.m_data}, {24'd0, e});
                end
            end
        end
    end

    // Drives one 8N1 frame starting at a negedge. ready_pulse raises m_ready for
    // exactly the cycle whose rising edge samples the stop bit (div = bclk).
    task automatic send_byte(input logic [7:0] b, input logic stop, input int unsigned bclk,
                             input bit expect_ok, input bit ready_pulse);
        logic [7:0] bv;
        bv = b;
        if (expect_ok) exp_q.push_back(bv);
        ser_rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = bv[i];
            repeat (bclk) @(negedge clk);
        end
        ser_rx = stop;
        if (ready_pulse) begin
            repeat (bclk / 2 + 2) @(negedge clk);
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
            repeat (bclk - bclk / 2 - 3) @(negedge clk);
        end else begin
            repeat (bclk) @(negedge clk);
        end
        ser_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetn      = 1'b0;
        ser_rx      = 1'b1;
        cfg_div     = 16'd6;
        err_clr     = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: two frames, consumer always ready, one valid cycle each.
        bus.m_ready = 1'b1;
        valid_cycles = 0;
        send_byte(8'h55, 1'b1, 6, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 6, 1'b1, 1'b0);
        wait_drain(100);
        check("t1_valid_cycles", valid_cycles, 2);
        check("t1_frame_err", frame_err, 0);
        check("t1_overrun", overrun, 0);

        // 2: 2-clock glitch is rejected.
        valid_cycles = 0;
        ser_rx = 1'b0;
        repeat (2) @(negedge clk);
        ser_rx = 1'b1;
        repeat (80) @(negedge clk);
        check("t2_valid_cycles", valid_cycles, 0);
        check("t2_frame_err", frame_err, 0);

        // 3: bad stop bit.
        valid_cycles = 0;
        send_byte(8'h3C, 1'b0, 6, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("t3_frame_err_set", frame_err, 1);
        check("t3_no_byte", valid_cycles, 0);
        pulse_clr();
        check("t3_frame_err_clr", frame_err, 0);

        // Break: one framing error, no restart while held low.
        ser_rx = 1'b0;
        repeat (70) @(negedge clk);
        check("brk_frame_err_set", frame_err, 1);
        pulse_clr();
        repeat (80) @(negedge clk);
        check("brk_no_retrigger", frame_err, 0);
        check("brk_no_byte", valid_cycles, 0);
        ser_rx = 1'b1;
        repeat (10) @(negedge clk);
        send_byte(8'hC3, 1'b1, 6, 1'b1, 1'b0);
        wait_drain(100);

        // 4: overrun with consumer stalled.
        bus.m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] v;
            v = 8'(i);
            send_byte(v, 1'b1, 6, (i <= 4), 1'b0);
        end
        check("t4_overrun", overrun, 1);
        check("t4_full_valid", bus.m_valid, 1);
        check("t4_head", bus.m_data, 8'h01);
        bus.m_ready = 1'b1;
        wait_drain(50);
        check("t4_empty_after", bus.m_valid, 0);
        pulse_clr();
        check("t4_overrun_clr", overrun, 0);

        // 5: full FIFO, pop coincides with 5th byte completion.
        bus.m_ready = 1'b0;
        send_byte(8'h10, 1'b1, 6, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 6, 1'b1, 1'b0);
        send_byte(8'h30, 1'b1, 6, 1'b1, 1'b0);
        send_byte(8'h40, 1'b1, 6, 1'b1, 1'b0);
        send_byte(8'h50, 1'b1, 6, 1'b1, 1'b1);
        check("t5_no_overrun", overrun, 0);
        bus.m_ready = 1'b1;
        wait_drain(50);
        check("t5_empty_after", bus.m_valid, 0);

        // 6: reset mid-frame, then cfg_div=1 acts as 2.
        ser_rx = 1'b0;
        repeat (6) @(negedge clk);
        ser_rx = 1'b1;
        repeat (12) @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_partial", bus.m_valid, 0);
        check("t6_frame_err", frame_err, 0);
        cfg_div = 16'd1;
        send_byte(8'h81, 1'b1, 2, 1'b1, 1'b0);
        wait_drain(50);
        check("t6_frame_err_div1", frame_err, 0);
        check("t6_overrun", overrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
